// File: rtl/storage_arbiter_pkg.sv
// Shared definitions for the storage arbiter: FSM state encoding,
// requester index assignments and default bus widths.
package storage_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int REQ_MENU    = 0;
    localparam int REQ_HISTORY = 1;
    localparam int REQ_PLAY    = 2;

    localparam int N_REQ_DEF   = 3;
    localparam int ID_W_DEF    = 8;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 1023;

endpackage

// File: rtl/storage_arbiter_rr_picker.sv
// Round-robin picker: scans the eligible mask starting at ptr and wrapping,
// returns the first hit as a one-hot vector plus its index. Purely combinational.
module storage_arbiter_rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    // first eligible requester at or after ptr, wrapping modulo N
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && elig[(int'(ptr) + i) % N]) begin
                any                       = 1'b1;
                pick[(int'(ptr) + i) % N] = 1'b1;
                pick_idx                  = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/storage_arbiter.sv
// Shares one storage backend among the page controllers. Each granted
// request becomes one backend strobe, a wait for mem_ready and a done pulse.
// Optional backend timeout: define STORAGE_ARB_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | no transaction; grant an eligible requester round-robin
//  ISSUE | mem_en strobe with the latched we/id/wdata
//  WAIT  | waiting for mem_ready (or timeout when enabled)
//  DONE  | done/err pulse; gnt drops and ptr advances on exit
module storage_arbiter
    import storage_arbiter_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int ID_W    = ID_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ID_W-1:0]   req_id,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic                    err,
    output logic [DATA_W-1:0]       rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ID_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_ready
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [N_REQ-1:0]   elig;
    logic [N_REQ-1:0]   pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               sel_we;
    logic [ID_W-1:0]    sel_id;
    logic [DATA_W-1:0]  sel_wdata;

`ifdef STORAGE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   wait_cnt;
`else
    logic               unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // id 0 is "no operation" and never competes
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req[i] && (req_id[i*ID_W +: ID_W] != '0);
        end
    end

    storage_arbiter_rr_picker #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .elig     (elig),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    // route the picked requester's command fields to the latch point
    always_comb begin
        sel_we    = 1'b0;
        sel_id    = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                sel_we    = req_we[i];
                sel_id    = req_id[i*ID_W +: ID_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // transaction sequencer; every output is a register of this block
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef STORAGE_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            done   <= '0;
            err    <= 1'b0;
            mem_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt       <= pick;
                        gnt_idx   <= pick_idx;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_id;
                        mem_wdata <= sel_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef STORAGE_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    // mem_we still holds the latched direction of this access
                    if (mem_ready) begin
                        done  <= gnt;
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        state <= DONE;
                    end
`ifdef STORAGE_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        done  <= gnt;
                        err   <= 1'b1;
                        rdata <= '0;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    gnt   <= '0;
                    ptr   <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed self-checking bench for storage_arbiter. The timeout scenario
// runs only when STORAGE_ARB_TIMEOUT_EN is defined.
module tb_storage_arbiter;
    import storage_arbiter_pkg::*;

    localparam int N_REQ  = 3;
    localparam int ID_W   = 8;
    localparam int DATA_W = 32;

    logic                    clk = 1'b0;
    logic                    sys_rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ID_W-1:0]   req_id;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic                    err;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [ID_W-1:0]         mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    storage_arbiter #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .req       (req),
        .req_we    (req_we),
        .req_id    (req_id),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  exp_gnt;
        logic [7:0]  exp_addr;
        logic        saw_gnt1;
        int          cyc;

        sys_rst   = 1'b1;
        req       = '0;
        req_we    = '0;
        req_id    = '0;
        req_wdata = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        tick();
        tick();
        check("rst_gnt",   gnt,   3'b000);
        check("rst_done",  done,  3'b000);
        check("rst_err",   err,   1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem",   {mem_en, mem_we, mem_addr, mem_wdata}, '0);
        sys_rst = 1'b0;
        tick();

        // single read by the menu requester
        req_id[REQ_MENU*ID_W +: ID_W] = 8'd5;
        req[REQ_MENU] = 1'b1;
        tick();
        check("rd_gnt",    gnt,      3'b001);
        check("rd_mem_en", mem_en,   1'b1);
        check("rd_addr",   mem_addr, 8'd5);
        check("rd_we",     mem_we,   1'b0);
        req = '0;
        tick();
        check("rd_en_pulse", mem_en, 1'b0);
        tick();
        tick();
        check("rd_no_early_done", done, 3'b000);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ready = 1'b0;
        check("rd_done",  done,  3'b001);
        check("rd_rdata", rdata, 32'hDEADBEEF);
        check("rd_err",   err,   1'b0);
        tick();
        check("rd_done_clr", done, 3'b000);
        check("rd_gnt_clr",  gnt,  3'b000);

        // reset in the middle of WAIT, ptr is 1 at this point
        req_id = {8'd4, 8'd2, 8'd1};
        req    = 3'b100;
        tick();
        check("rw_gnt", gnt, 3'b100);
        tick();
        tick();
        sys_rst   = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rw_gnt0",   gnt,    3'b000);
        check("rw_en0",    mem_en, 1'b0);
        check("rw_rdata0", rdata,  32'h0);
        check("rw_addr0",  mem_addr, 8'h0);
        tick();
        check("rw_no_done", done, 3'b000);
        mem_ready = 1'b0;
        req       = 3'b111;
        sys_rst   = 1'b0;

        // contention with backend latency 1: order 0,1,2,0 proves ptr reset to 0
        for (int n = 0; n < 4; n++) begin
            exp_gnt  = 3'b001 << (n % 3);
            exp_addr = (n % 3 == 0) ? 8'd1 : (n % 3 == 1) ? 8'd2 : 8'd4;
            cyc = 0;
            while (!mem_en && cyc < 10) begin
                tick();
                cyc++;
            end
            check("ct_grant_bound", (cyc < 10), 1'b1);
            check("ct_gnt",  gnt,      exp_gnt);
            check("ct_addr", mem_addr, exp_addr);
            tick();
            mem_ready = 1'b1;
            mem_rdata = 32'h100 + n;
            tick();
            mem_ready = 1'b0;
            check("ct_done",  done,  exp_gnt);
            check("ct_rdata", rdata, 32'h100 + n);
            if (n == 3) req = '0;
            tick();
            check("ct_done_once", done, 3'b000);
        end

        // ptr is now 1; requester 1 has id 0 and must be skipped
        req_id = {8'd9, 8'd0, 8'd1};
        req    = 3'b110;
        saw_gnt1 = 1'b0;
        tick();
        check("z_gnt",  gnt,      3'b100);
        check("z_addr", mem_addr, 8'd9);
        req[2] = 1'b0;
        saw_gnt1 = saw_gnt1 | gnt[1];
        tick();
        saw_gnt1 = saw_gnt1 | gnt[1];
        mem_ready = 1'b1;
        mem_rdata = 32'h55;
        tick();
        mem_ready = 1'b0;
        check("z_done", done, 3'b100);
        for (int i = 0; i < 4; i++) begin
            saw_gnt1 = saw_gnt1 | gnt[1];
            tick();
        end
        check("z_gnt1_never", saw_gnt1, 1'b0);
        req = '0;

        // mem_ready in IDLE is ignored
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF;
        tick();
        mem_ready = 1'b0;
        tick();
        check("idle_ready_done",  done,  3'b000);
        check("idle_ready_rdata", rdata, 32'h55);

        // write from play, request dropped during ISSUE; ptr is 0
        req_id[REQ_PLAY*ID_W +: ID_W]       = 8'd3;
        req_wdata[REQ_PLAY*DATA_W +: DATA_W] = 32'h12;
        req_we[REQ_PLAY] = 1'b1;
        req[REQ_PLAY]    = 1'b1;
        tick();
        check("wr_gnt",   gnt,       3'b100);
        check("wr_we",    mem_we,    1'b1);
        check("wr_wdata", mem_wdata, 32'h12);
        check("wr_addr",  mem_addr,  8'd3);
        req = '0;
        req_wdata[REQ_PLAY*DATA_W +: DATA_W] = 32'h99;
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD;
        tick();
        mem_ready = 1'b0;
        check("wr_done",  done,  3'b100);
        check("wr_rdata", rdata, 32'h55);
        tick();
        check("wr_gnt_clr", gnt, 3'b000);
        req_we = '0;

`ifdef STORAGE_ARB_TIMEOUT_EN
        // timeout after 8 WAIT cycles; ptr is 0
        tick();
        req_id[REQ_MENU*ID_W +: ID_W] = 8'd7;
        req[REQ_MENU] = 1'b1;
        tick();
        check("to_gnt", gnt, 3'b001);
        req = '0;
        for (int i = 0; i < 9; i++) begin
            check("to_no_early_done", done, 3'b000);
            tick();
        end
        check("to_done",  done,  3'b001);
        check("to_err",   err,   1'b1);
        check("to_rdata", rdata, 32'h0);
        tick();
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h77;
        tick();
        mem_ready = 1'b0;
        check("to_late_done", done,   3'b000);
        check("to_late_idle", {gnt, mem_en}, 4'b0000);
        check("to_late_rdata", rdata, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
